iic_target_regs: RTL and testbench
==================================

Name: iic_target_regs

Overview:
- I2C target (slave) that answers a touch-controller-style initiator.
- Uses a 7-bit device address, a 16-bit big-endian register pointer with auto-increment, and a 64-byte register window backed by local RAM.
- A local host port preloads window bytes (status byte, point records) so the touch-panel side can be emulated for bring-up and simulation against the touch-screen controller.
- Every I2C data write, inside or outside the window, is reported to the host on a strobe.

Parameters:
- DEV_ADDR, 7'h5D, 7-bit target address matched in the address byte.
- WIN_BASE, 16'h8140, register address mapped to window byte 0; the window covers WIN_BASE..WIN_BASE+63.
- SYNC_STAGES, 2, synchronizer depth on scl_i and sda_i.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL level, asynchronous.
- sda_i  in  1  bus SDA level, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release the line (open-drain).
- loc_we  in  1  host write strobe.
- loc_addr  in  6  host window byte index.
- loc_wdata  in  8  host write data.
- loc_rdata  out  8  window[loc_addr], registered, 1-cycle latency.
- wr_strobe  out  1  1-cycle pulse per I2C data byte written.
- wr_addr  out  16  register address of that byte.
- wr_data  out  8  the written byte.
- busy  out  1  high from START to STOP or abort.

Behaviour:
- Reset values: sda_oe=0, loc_rdata=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, FSM in IDLE, pointer=0. Window RAM is not cleared.
- Input conditioning: scl/sda pass through SYNC_STAGES flops, then one more flop for edge detection. Edges are therefore seen SYNC_STAGES+1 cycles late. Bus phases of at least 8 clk are supported.
- START: synced sda falls while scl is high, in any state. Enter DEV_ADDR, bit counter=0, busy=1, release sda. A repeated START keeps the register pointer.
- STOP: synced sda rises while scl is high. Enter IDLE, busy=0, sda_oe=0.
- Bit sampling: sda is sampled on scl rising edges, MSB first.
- Drive timing: sda_oe changes only on a detected scl falling edge, never while scl is high.
- DEV_ADDR: collect 8 bits; bit0 = R/W.
  - If addr == DEV_ADDR: ACK on the following falling edge (sda_oe=1 for one SCL low/high period), then go to ADDR_HI (write) or READ.
  - On mismatch: no ACK, go to IDLE until the next START.
- ADDR_HI / ADDR_LO: each takes 8 bits into pointer[15:8] / pointer[7:0], and each is ACKed. After ADDR_LO, go to WRITE.
- WRITE: collect 8 bits, then ACK.
  - On the 8th rising edge: wr_strobe pulses for 1 clk with wr_addr=pointer and wr_data=byte.
  - If the pointer is inside the window, RAM[pointer-WIN_BASE] is written; outside the window the write is ignored but still ACKed.
  - Then pointer += 1 (16-bit wrap, 16'hFFFF -> 0).
- READ: on the falling edge that ends the address ACK, load the shift register with RAM[pointer-WIN_BASE], or 8'h00 if outside the window; pointer += 1.
  - Drive sda_oe = ~bit on each falling edge for 8 bits, then release for the initiator ACK.
  - Initiator ACK (sda low at the rising edge): load the next byte on the next falling edge and continue.
  - Initiator NACK: release sda and wait in IDLE_WAIT until STOP or START.
- Local port:
  - loc_we writes RAM[loc_addr] at the clock edge.
  - The read port is independent; a write and read to the same address in the same cycle return the old data.
  - Same-cycle collision with an I2C write to the same byte: the I2C write wins and the local write is dropped.
  - A local write during READ affects only bytes not yet loaded into the shift register.
- Reset asserted mid-transfer: sda_oe=0 immediately (asynchronous), FSM returns to IDLE, no partial strobe.
- Initiator ACK detection uses the synced sda level only; the target never stretches SCL.

Test Plan:
- Preload RAM[14]=8'h83 via loc_we. I2C write 0xBA, 0x81, 0x4E, repeated START, 0xBB, read 1 byte, NACK, STOP -> four ACKs observed, read data 0x83, busy returns to 0, sda_oe=0.
- Preload RAM[16..55]=i. Burst read 40 bytes from 0x8150 -> bytes 0x10..0x37 in order, ACK on all but the last.
- Write 0x814E then data 0x00 -> wr_strobe once, wr_addr=0x814E, wr_data=0x00; loc_rdata at index 14 reads 0x00.
- Write 0x8040 then data 0x02 -> ACK given, wr_strobe with wr_addr=0x8040, wr_data=0x02; RAM unchanged.
- Address byte 0xA0 (wrong device) -> no ACK, sda_oe stays 0 for the whole frame, no wr_strobe.
- Pointer 0xFFFF, write 2 bytes -> wr_addr sequence 0xFFFF then 0x0000. Separately, assert rstn low during a READ with sda_oe=1 -> sda_oe=0 within the same cycle, busy=0.

Source files
------------

// File: rtl/iic_target_regs.sv
// iic_target_regs: I2C target with a 16-bit auto-increment register pointer into a 64-byte host-preloadable window.
module iic_target_regs #(
  parameter logic [6:0]  DEV_ADDR    = 7'h5D,
  parameter logic [15:0] WIN_BASE    = 16'h8140,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        loc_we,
  input  logic [5:0]  loc_addr,
  input  logic [7:0]  loc_wdata,
  output logic [7:0]  loc_rdata,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);
  typedef enum logic [2:0] {S_IDLE, S_DEV, S_AHI, S_ALO, S_WR, S_RD, S_WAIT} state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0] r_scl_s, r_sda_s;
  logic r_scl_d, r_sda_d, r_ack, w_ack, r_nack, w_nack, r_oe, w_oe, r_strobe;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_sh, w_sh, r_loc_rdata, r_wdata, w_byte, w_rbyte;
  logic [15:0] r_ptr, w_ptr, r_waddr, w_off;
  logic [7:0] r_mem [64];
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_in, w_wr_bit;

  assign w_scl    = r_scl_s[SYNC_STAGES-1];
  assign w_sda    = r_sda_s[SYNC_STAGES-1];
  assign w_rise   = w_scl & ~r_scl_d;
  assign w_fall   = ~w_scl & r_scl_d;
  assign w_start  = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop   = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_off    = r_ptr - WIN_BASE;
  assign w_in     = w_off < 16'd64;
  assign w_byte   = {r_sh[6:0], w_sda};
  assign w_rbyte  = w_in ? r_mem[w_off[5:0]] : 8'h00;
  assign w_wr_bit = (r_state == S_WR) && w_rise && (r_cnt == 4'd7);

  assign sda_oe    = r_oe;
  assign loc_rdata = r_loc_rdata;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_waddr;
  assign wr_data   = r_wdata;
  assign busy      = r_state != S_IDLE;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ack   = r_ack;
    w_nack  = r_nack;
    w_sh    = r_sh;
    w_ptr   = r_ptr;
    w_oe    = r_oe;
    if (w_start) begin
      w_state = S_DEV;
      w_cnt   = 4'd0;
      w_ack   = 1'b0;
      w_oe    = 1'b0;
    end else if (w_stop) begin
      w_state = S_IDLE;
      w_ack   = 1'b0;
      w_oe    = 1'b0;
    end else if (r_state != S_IDLE && r_state != S_WAIT) begin
      if (w_rise) begin
        if (r_cnt < 4'd8) begin
          w_cnt = r_cnt + 4'd1;
          if (r_state != S_RD) w_sh = w_byte;
        end else w_nack = w_sda;
        if (w_wr_bit) w_ptr = r_ptr + 16'd1;
        else if (r_state == S_AHI && r_cnt == 4'd7) w_ptr = {w_byte, r_ptr[7:0]};
        else if (r_state == S_ALO && r_cnt == 4'd7) w_ptr = {r_ptr[15:8], w_byte};
      end else if (w_fall) begin
        if (r_ack) begin
          w_ack = 1'b0;
          w_cnt = 4'd0;
          w_oe  = 1'b0;
          if (r_state == S_DEV && !r_sh[0]) w_state = S_AHI;
          else if (r_state == S_AHI) w_state = S_ALO;
          else if (r_state == S_ALO) w_state = S_WR;
          else if (r_state == S_RD && r_nack) w_state = S_WAIT;
          else if (r_state != S_WR) begin
            // first bit of the next read byte goes out on the same fall that ends the ACK slot
            w_state = S_RD;
            w_sh    = w_rbyte;
            w_oe    = ~w_rbyte[7];
            w_ptr   = r_ptr + 16'd1;
          end
        end else if (r_cnt == 4'd8) begin
          if (r_state == S_DEV && r_sh[7:1] != DEV_ADDR) w_state = S_IDLE;
          else begin
            w_ack = 1'b1;
            w_oe  = r_state != S_RD;
          end
        end else if (r_state == S_RD && r_cnt != 4'd0) begin
          w_sh = {r_sh[6:0], 1'b0};
          w_oe = ~r_sh[6];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scl_s     <= '1;
      r_sda_s     <= '1;
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ack       <= 1'b0;
      r_nack      <= 1'b0;
      r_sh        <= 8'h00;
      r_ptr       <= 16'h0000;
      r_oe        <= 1'b0;
      r_strobe    <= 1'b0;
      r_waddr     <= 16'h0000;
      r_wdata     <= 8'h00;
      r_loc_rdata <= 8'h00;
    end else begin
      r_scl_s     <= {r_scl_s[SYNC_STAGES-2:0], scl_i};
      r_sda_s     <= {r_sda_s[SYNC_STAGES-2:0], sda_i};
      r_scl_d     <= w_scl;
      r_sda_d     <= w_sda;
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_ack       <= w_ack;
      r_nack      <= w_nack;
      r_sh        <= w_sh;
      r_ptr       <= w_ptr;
      r_oe        <= w_oe;
      r_strobe    <= w_wr_bit;
      r_loc_rdata <= r_mem[loc_addr];
      if (w_wr_bit) begin
        r_waddr <= r_ptr;
        r_wdata <= w_byte;
      end
    end
  end

  // the I2C write is issued last so it overrides a same-byte local write
  always_ff @(posedge clk) begin
    if (loc_we) r_mem[loc_addr] <= loc_wdata;
    if (w_wr_bit && w_in) r_mem[w_off[5:0]] <= w_byte;
  end
endmodule

// File: tb/tb_iic_target_regs.sv
// tb_iic_target_regs: directed I2C initiator plus transaction-level register-window model for iic_target_regs.
module tb_iic_target_regs;
  localparam int Q = 10;
  logic clk = 1'b0, rstn = 1'b0, scl = 1'b1, m_sda = 1'b1, loc_we = 1'b0;
  logic [5:0] loc_addr = 6'd0;
  logic [7:0] loc_wdata = 8'h00;
  logic sda_oe, wr_strobe, busy, sda_bus;
  logic [7:0] loc_rdata, wr_data;
  logic [15:0] wr_addr;
  int checks = 0, errors = 0;
  logic [7:0] mdl_mem [64];
  logic [15:0] mptr = 16'h0000;
  logic [23:0] exp_wr [$];
  logic [15:0] wr_log [$];
  logic [7:0] tx [64];
  logic oe_seen = 1'b0, prev_oe = 1'b0;

  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  iic_target_regs dut (
    .clk(clk), .rstn(rstn), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] p);
    return p >= 16'h8140 && p <= 16'h817F;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_clk(input logic b, output logic s);
    m_sda = b;
    hold(Q);
    scl = 1'b1;
    hold(Q / 2);
    s = sda_bus;
    hold(Q / 2);
    scl = 1'b0;
  endtask

  task automatic m_start;
    m_sda = 1'b1;
    hold(Q);
    scl = 1'b1;
    hold(Q);
    m_sda = 1'b0;
    hold(Q);
    scl = 1'b0;
  endtask

  task automatic m_stop;
    m_sda = 1'b0;
    hold(Q);
    scl = 1'b1;
    hold(Q);
    m_sda = 1'b1;
    hold(Q);
  endtask

  task automatic m_send(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
    bit_clk(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_recv(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, s);
      b[i] = s;
    end
    bit_clk(nack, s);
  endtask

  task automatic loc_write(input int a, input logic [7:0] d);
    @(negedge clk);
    loc_we = 1'b1;
    loc_addr = 6'(a);
    loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic loc_read(input int a, output logic [7:0] d);
    @(negedge clk);
    loc_addr = 6'(a);
    @(negedge clk);
    d = loc_rdata;
    check("loc_rdata", d, mdl_mem[a]);
  endtask

  task automatic i2c_write(input logic [15:0] p, input int n, input bit do_stop);
    logic ack;
    m_start;
    m_send({7'h5D, 1'b0}, ack);
    check("addr_w_ack", ack, 1);
    m_send(p[15:8], ack);
    check("ptr_hi_ack", ack, 1);
    m_send(p[7:0], ack);
    check("ptr_lo_ack", ack, 1);
    mptr = p;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({mptr, tx[i]});
      if (in_win(mptr)) mdl_mem[int'(mptr) - 32'h8140] = tx[i];
      m_send(tx[i], ack);
      check("data_ack", ack, 1);
      mptr = mptr + 16'd1;
    end
    if (do_stop) m_stop;
  endtask

  task automatic i2c_read(input int n, output logic [7:0] first, output logic [7:0] last);
    logic ack;
    logic [7:0] b;
    m_start;
    m_send({7'h5D, 1'b1}, ack);
    check("addr_r_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      m_recv(i == n - 1, b);
      check("rd_data", b, in_win(mptr) ? mdl_mem[int'(mptr) - 32'h8140] : 8'h00);
      if (i == 0) first = b;
      last = b;
      mptr = mptr + 16'd1;
    end
    m_stop;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (sda_oe) oe_seen = 1'b1;
      if (sda_oe !== prev_oe) check("oe_change_scl_low", scl, 0);
      if (wr_strobe) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_strobe: got addr %h data %h expected no strobe", wr_addr, wr_data);
        end else begin
          logic [23:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", wr_addr, e[23:8]);
          check("wr_data", wr_data, e[7:0]);
          wr_log.push_back(wr_addr);
        end
      end
    end
    prev_oe = sda_oe;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] f, l, d;
    logic ack;
    hold(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    rstn = 1'b1;
    hold(5);
    loc_write(0, 8'h55);
    loc_write(14, 8'h83);
    for (int i = 16; i < 56; i++) loc_write(i, 8'(i));

    i2c_write(16'h814E, 0, 1'b0);
    check("busy_mid", busy, 1);
    i2c_read(1, f, l);
    check("t1_byte", f, 8'h83);
    check("t1_busy_end", busy, 0);
    check("t1_oe_end", sda_oe, 0);

    i2c_write(16'h8150, 0, 1'b0);
    i2c_read(40, f, l);
    check("t2_first", f, 8'h10);
    check("t2_last", l, 8'h37);

    tx[0] = 8'h00;
    i2c_write(16'h814E, 1, 1'b1);
    loc_read(14, d);
    check("t3_ram14", d, 8'h00);

    tx[0] = 8'h02;
    i2c_write(16'h8040, 1, 1'b1);
    loc_read(0, d);
    check("t4_ram0", d, 8'h55);

    oe_seen = 1'b0;
    m_start;
    m_send(8'hA0, ack);
    check("t5_nack_addr", ack, 0);
    m_send(8'h81, ack);
    check("t5_nack_b1", ack, 0);
    m_send(8'h40, ack);
    check("t5_nack_b2", ack, 0);
    m_stop;
    check("t5_oe_never", oe_seen, 0);

    tx[0] = 8'hAA;
    tx[1] = 8'h55;
    i2c_write(16'hFFFF, 2, 1'b1);
    hold(2);
    check("log_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("log0", wr_log[0], 16'h814E);
      check("log1", wr_log[1], 16'h8040);
      check("log2", wr_log[2], 16'hFFFF);
      check("log3", wr_log[3], 16'h0000);
    end

    i2c_write(16'h8140, 0, 1'b0);
    m_start;
    m_send({7'h5D, 1'b1}, ack);
    check("t6_addr_ack", ack, 1);
    hold(Q);
    check("t6_oe_driving", sda_oe, 1);
    rstn = 1'b0;
    #1;
    check("t6_oe_async", sda_oe, 0);
    check("t6_busy", busy, 0);
    hold(3);
    scl = 1'b1;
    m_sda = 1'b1;
    rstn = 1'b1;
    hold(Q);
    check("t6_busy_after", busy, 0);
    check("exp_wr_drained", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
